mem_arbiter: RTL and testbench

Sequences and shares the single memory port (MAR, MDR, memory enable, MFC handshake) between the instruction-fetch FSM and the execute unit's load/store path. Accepts one request at a time and drives the MAR/MDR/memory control strobes in the order the datapath requires. Returns read data and a one-cycle acknowledge to the winning requester. Sits between the IF/EX controllers and the PC/MAR/MDR/memory datapath.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_watchdog.sv | 30 +++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_EX = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACCESS,
    XFER,
    RESP
  } state_t;

  // Request captured from the winning requester in IDLE
  typedef struct packed {
    logic              id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus the MAR/MDR/memory strobe bundle.
// master: IF/EX controllers and memory side; slave: the arbiter.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              ex_req;
  logic              ex_we;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic              ex_ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mar_addr;
  logic              marIn;
  logic [DATA_W-1:0] mdr_wdata;
  logic              mdrIn;
  logic              memEN;
  logic              RW;
  logic              MFC;
  logic [DATA_W-1:0] mem_rdata;
  logic              mdReadEN;
  logic              mdrOut;
  logic              busy;
  logic              timeout_err;

  modport master (
    output if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata, MFC, mem_rdata,
    input  if_ack, ex_ack, rdata, mar_addr, marIn, mdr_wdata, mdrIn, memEN, RW,
           mdReadEN, mdrOut, busy, timeout_err
  );

  modport slave (
    input  if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata, MFC, mem_rdata,
    output if_ack, ex_ack, rdata, mar_addr, marIn, mdr_wdata, mdrIn, memEN, RW,
           mdReadEN, mdrOut, busy, timeout_err
  );

endinterface

// File: rtl/mem_watchdog.sv
// Counts consecutive ACCESS cycles; done_c flags the LIMIT-th one.
module mem_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic done_c
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count;

  // Cycle counter, cleared whenever the FSM is not in ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count != CNT_W'(LIMIT - 1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done_c = en && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single MAR/MDR memory port between instruction fetch and
// execute load/store. One access at a time, EX-priority with alternation.
// Optional: define MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles
// without MFC (ack with timeout_err and all-ones read data).
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  state_t            state, state_d;
  req_t              req_q, req_d;
  logic              last_ex, last_ex_d;
  logic [DATA_W-1:0] rdata, rdata_d;
  logic              mar_in, mar_in_d;
  logic              mdr_in, mdr_in_d;
  logic              mem_en, mem_en_d;
  logic              rw, rw_d;
  logic              md_read_en, md_read_en_d;
  logic              mdr_out, mdr_out_d;
  logic              if_ack, if_ack_d;
  logic              ex_ack, ex_ack_d;
  logic              busy, busy_d;
  logic              timeout_err, timeout_err_d;
  logic              access_c;
  logic              wd_done_c;

  assign access_c = (state == ACCESS);

`ifdef MEM_TIMEOUT_EN
  mem_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .en     (access_c),
    .done_c (wd_done_c)
  );
`else
  assign wd_done_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, next strobe values and request capture
  always_comb begin
    state_d       = state;
    req_d         = req_q;
    last_ex_d     = last_ex;
    rdata_d       = rdata;
    mar_in_d      = 1'b0;
    mdr_in_d      = 1'b0;
    mem_en_d      = 1'b0;
    rw_d          = 1'b0;
    md_read_en_d  = 1'b0;
    mdr_out_d     = 1'b0;
    if_ack_d      = 1'b0;
    ex_ack_d      = 1'b0;
    timeout_err_d = 1'b0;

    case (state)
      IDLE: begin
        // EX normally wins; after an EX grant a pending fetch goes first
        if (bus.ex_req && !(last_ex && bus.if_req)) begin
          req_d = '{id: REQ_EX, we: bus.ex_we, addr: bus.ex_addr, wdata: bus.ex_wdata};
        end else if (bus.if_req) begin
          req_d = '{id: REQ_IF, we: 1'b0, addr: bus.if_addr, wdata: req_q.wdata};
        end
        if (bus.ex_req || bus.if_req) begin
          state_d  = ADDR;
          mar_in_d = 1'b1;
          mdr_in_d = req_d.we;
        end
      end
      ADDR: begin
        state_d  = ACCESS;
        mem_en_d = 1'b1;
        rw_d     = ~req_q.we;
      end
      ACCESS: begin
        if (bus.MFC) begin
          state_d      = XFER;
          md_read_en_d = ~req_q.we;
        end else if (wd_done_c) begin
          state_d       = RESP;
          if_ack_d      = (req_q.id == REQ_IF);
          ex_ack_d      = (req_q.id == REQ_EX);
          timeout_err_d = 1'b1;
          rdata_d       = '1;
        end else begin
          mem_en_d = 1'b1;
          rw_d     = ~req_q.we;
        end
      end
      XFER: begin
        state_d  = RESP;
        if_ack_d = (req_q.id == REQ_IF);
        ex_ack_d = (req_q.id == REQ_EX);
        if (!req_q.we) begin
          mdr_out_d = 1'b1;
          rdata_d   = bus.mem_rdata;
        end
      end
      RESP: begin
        state_d   = IDLE;
        last_ex_d = (req_q.id == REQ_EX);
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Registered outputs, latched request and last-grant flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      last_ex     <= 1'b0;
      rdata       <= '0;
      mar_in      <= 1'b0;
      mdr_in      <= 1'b0;
      mem_en      <= 1'b0;
      rw          <= 1'b0;
      md_read_en  <= 1'b0;
      mdr_out     <= 1'b0;
      if_ack      <= 1'b0;
      ex_ack      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req_q       <= req_d;
      last_ex     <= last_ex_d;
      rdata       <= rdata_d;
      mar_in      <= mar_in_d;
      mdr_in      <= mdr_in_d;
      mem_en      <= mem_en_d;
      rw          <= rw_d;
      md_read_en  <= md_read_en_d;
      mdr_out     <= mdr_out_d;
      if_ack      <= if_ack_d;
      ex_ack      <= ex_ack_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

  assign bus.mar_addr    = req_q.addr;
  assign bus.mdr_wdata   = req_q.wdata;
  assign bus.rdata       = rdata;
  assign bus.marIn       = mar_in;
  assign bus.mdrIn       = mdr_in;
  assign bus.memEN       = mem_en;
  assign bus.RW          = rw;
  assign bus.mdReadEN    = md_read_en;
  assign bus.mdrOut      = mdr_out;
  assign bus.if_ack      = if_ack;
  assign bus.ex_ack      = ex_ack;
  assign bus.busy        = busy;
  assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner
// sequences and random traffic against a transaction-level model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] tb_mem  [16];
  logic [15:0] ref_mem [16];

  typedef struct {
    int          who;
    int          lat;
    logic [15:0] rdata;
    logic        tmo;
    int          n_mar;
    int          n_mdrin;
    int          n_mem;
    int          n_rw1;
    int          n_rd;
    int          n_out;
    int          n_multi;
    int          n_busy0;
    logic [15:0] mar_a;
    logic [15:0] mdr_d;
  } res_t;

  typedef struct {
    logic        if_on;
    logic [15:0] if_a;
    logic        ex_on;
    logic        ex_we;
    logic [15:0] ex_a;
    logic [15:0] ex_d;
    int          delay;
    int          exp_who;
    int          exp_lat;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction: drive requests in an IDLE cycle, act as memory, watch strobes
  task automatic do_txn(input logic if_on, input logic [15:0] if_a, input logic ex_on,
                        input logic ex_we_i, input logic [15:0] ex_a, input logic [15:0] ex_d,
                        input int delay, output res_t r);
    r = '{default: 0};
    r.lat = -1;
    @(posedge clk); #1;
    check("idle_before_req", {29'd0, bus.if_ack, bus.ex_ack, bus.busy}, 32'd0);
    bus.if_req   = if_on;
    bus.if_addr  = if_a;
    bus.ex_req   = ex_on;
    bus.ex_we    = ex_we_i;
    bus.ex_addr  = ex_a;
    bus.ex_wdata = ex_d;
    for (int t = 1; t <= 80; t++) begin
      @(posedge clk); #1;
      if (bus.marIn) begin r.n_mar++; r.mar_a = bus.mar_addr; end
      if (bus.mdrIn) begin r.n_mdrin++; r.mdr_d = bus.mdr_wdata; end
      if (bus.mdReadEN) r.n_rd++;
      if (bus.mdrOut) r.n_out++;
      if (!bus.busy) r.n_busy0++;
      if (int'(bus.memEN) + int'(bus.mdReadEN) + int'(bus.mdrOut) + int'(bus.marIn) > 1)
        r.n_multi++;
      bus.MFC = 1'b0;
      if (bus.memEN) begin
        if (bus.RW) r.n_rw1++;
        if (r.n_mem == delay) begin
          bus.MFC = 1'b1;
          if (!bus.RW) tb_mem[bus.mar_addr[3:0]] = bus.mdr_wdata;
        end
        r.n_mem++;
      end
      bus.mem_rdata = tb_mem[bus.mar_addr[3:0]];
      if (bus.if_ack || bus.ex_ack) begin
        r.who   = (bus.if_ack && bus.ex_ack) ? 3 : (bus.ex_ack ? 2 : 1);
        r.lat   = t;
        r.rdata = bus.rdata;
        r.tmo   = bus.timeout_err;
        bus.if_req = 1'b0;
        bus.ex_req = 1'b0;
        return;
      end
    end
    bus.if_req = 1'b0;
    bus.ex_req = 1'b0;
    bus.MFC    = 1'b0;
  endtask

  task automatic check_res(input string tag, input res_t r, input int who, input int lat,
                           input logic we, input logic [15:0] addr, input logic [15:0] wd,
                           input int delay, input logic [15:0] rd);
    check({tag, "_who"}, r.who, who);
    check({tag, "_lat"}, r.lat, lat);
    check({tag, "_mar_cnt"}, r.n_mar, 1);
    check({tag, "_mar_addr"}, r.mar_a, addr);
    check({tag, "_mdrin_cnt"}, r.n_mdrin, we ? 1 : 0);
    check({tag, "_memen_cnt"}, r.n_mem, delay + 1);
    check({tag, "_rw_read_cnt"}, r.n_rw1, we ? 0 : delay + 1);
    check({tag, "_mdreaden_cnt"}, r.n_rd, we ? 0 : 1);
    check({tag, "_mdrout_cnt"}, r.n_out, we ? 0 : 1);
    check({tag, "_strobe_overlap"}, r.n_multi, 0);
    check({tag, "_busy_gap"}, r.n_busy0, 0);
    check({tag, "_timeout_err"}, r.tmo, 0);
    if (we) check({tag, "_mdr_wdata"}, r.mdr_d, wd);
    else    check({tag, "_rdata"}, r.rdata, rd);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit got=running want=finished");
    $fatal(1);
  end

  initial begin
    res_t        r;
    int          ack_who [4];
    int          ack_at  [4];
    logic [15:0] ack_rd  [4];
    int          nack;
    logic        if_p, ex_p, ewe, win_ex, last_ex;
    logic [15:0] if_a, ea, ed, wa;
    int          d;

    bus.if_req = 1'b0; bus.if_addr = '0; bus.ex_req = 1'b0; bus.ex_we = 1'b0;
    bus.ex_addr = '0; bus.ex_wdata = '0; bus.MFC = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) tb_mem[i] = 16'hA000 | 16'(i);
    tb_mem[4] = 16'hBEEF;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_strobes", {22'd0, bus.marIn, bus.mdrIn, bus.memEN, bus.RW, bus.mdReadEN,
                            bus.mdrOut, bus.if_ack, bus.ex_ack, bus.busy, bus.timeout_err}, 32'd0);
    check("reset_rdata", bus.rdata, 0);
    check("reset_mar_addr", bus.mar_addr, 0);
    check("reset_mdr_wdata", bus.mdr_wdata, 0);
    rst = 1'b0;

    // Directed vectors; grant order follows from the previous rows
    vt[0] = '{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1, 4, 16'hBEEF};
    vt[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234, 3, 2, 7, 16'h0000};
    vt[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000, 1, 2, 5, 16'h1234};
    vt[3] = '{1'b1, 16'h0008, 1'b1, 1'b1, 16'h0002, 16'h5555, 0, 1, 4, 16'hA008};
    vt[4] = '{1'b1, 16'h0004, 1'b1, 1'b0, 16'h0008, 16'h0000, 2, 2, 6, 16'hA008};
    vt[5] = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1, 4, 16'h1234};
    for (int i = 0; i < 6; i++) begin
      do_txn(vt[i].if_on, vt[i].if_a, vt[i].ex_on, vt[i].ex_we, vt[i].ex_a, vt[i].ex_d,
             vt[i].delay, r);
      check_res($sformatf("vec%0d", i), r, vt[i].exp_who, vt[i].exp_lat,
                (vt[i].exp_who == 2) && vt[i].ex_we,
                (vt[i].exp_who == 2) ? vt[i].ex_a : vt[i].if_a,
                vt[i].ex_d, vt[i].delay, vt[i].exp_rdata);
    end

    // Reset during ACCESS: everything drops at once, no ack afterwards
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0004;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_memen_before", bus.memEN, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_memen", bus.memEN, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_ack", {bus.if_ack, bus.ex_ack}, 0);
    bus.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    nack = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.if_ack || bus.ex_ack) nack++;
    end
    check("rst_mid_no_ack", nack, 0);
    do_txn(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0, 0, r);
    check_res("after_rst", r, 1, 4, 1'b0, 16'h0004, 16'h0, 0, 16'hBEEF);

    // Both requests held high: grants alternate, acks 5 cycles apart
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0003;
    bus.ex_req = 1'b1; bus.ex_we = 1'b0; bus.ex_addr = 16'h0005;
    nack = 0;
    for (int t = 1; t <= 40 && nack < 4; t++) begin
      @(posedge clk); #1;
      bus.MFC = bus.memEN;
      bus.mem_rdata = tb_mem[bus.mar_addr[3:0]];
      if (bus.if_ack || bus.ex_ack) begin
        ack_who[nack] = bus.ex_ack ? 2 : 1;
        ack_at[nack]  = t;
        ack_rd[nack]  = bus.rdata;
        nack++;
        if (nack == 4) begin bus.if_req = 1'b0; bus.ex_req = 1'b0; end
      end
    end
    bus.if_req = 1'b0; bus.ex_req = 1'b0; bus.MFC = 1'b0;
    check("alt_ack_count", nack, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("alt%0d_who", k), ack_who[k], (k % 2 == 0) ? 2 : 1);
      check($sformatf("alt%0d_at", k), ack_at[k], 4 + 5 * k);
      check($sformatf("alt%0d_rdata", k), ack_rd[k], (k % 2 == 0) ? 16'hA005 : 16'hA003);
    end

    // MFC withheld for 40 ACCESS cycles
    do_txn(1'b1, 16'h0006, 1'b0, 1'b0, 16'h0, 16'h0, 40, r);
`ifdef MEM_TIMEOUT_EN
    check("tmo_who", r.who, 1);
    check("tmo_lat", r.lat, 2 + 15);
    check("tmo_memen_cnt", r.n_mem, 15);
    check("tmo_flag", r.tmo, 1);
    check("tmo_rdata", r.rdata, 16'hFFFF);
    check("tmo_mdrout", r.n_out + r.n_rd, 0);
`else
    check("wait_who", r.who, 1);
    check("wait_lat", r.lat, 44);
    check("wait_busy_gap", r.n_busy0, 0);
    check("wait_memen_cnt", r.n_mem, 41);
    check("wait_flag", r.tmo, 0);
    check("wait_rdata", r.rdata, 16'hA006);
`endif

    // Random traffic against a transaction-level model
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      tb_mem[i]  = 16'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    last_ex = 1'b0; if_p = 1'b0; ex_p = 1'b0;
    if_a = '0; ea = '0; ed = '0; ewe = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!if_p && $urandom_range(0, 1) == 1) begin if_p = 1'b1; if_a = 16'($urandom); end
      if (!ex_p && $urandom_range(0, 1) == 1) begin
        ex_p = 1'b1; ewe = 1'($urandom_range(0, 1)); ea = 16'($urandom); ed = 16'($urandom);
      end
      if (!if_p && !ex_p) begin if_p = 1'b1; if_a = 16'($urandom); end
      d = int'($urandom_range(0, 3));
      win_ex = ex_p && !(last_ex && if_p);
      wa = win_ex ? ea : if_a;
      do_txn(if_p, if_a, ex_p, ewe, ea, ed, d, r);
      check_res($sformatf("rnd%0d", n), r, win_ex ? 2 : 1, 4 + d, win_ex && ewe, wa, ed, d,
                ref_mem[wa[3:0]]);
      if (win_ex) begin
        if (ewe) ref_mem[wa[3:0]] = ed;
        ex_p = 1'b0;
      end else begin
        if_p = 1'b0;
      end
      last_ex = win_ex;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
